regfile_writeback: RTL and testbench

Writeback sequencer driving the single write port of the 32-entry register file. After reset it sweeps every register to zero (the register file has no reset of its own), then accepts writeback requests from the memory (load) stage and the ALU stage through valid/ready handshakes, buffers them in a small FIFO and retires one write per cycle. Sits between the execute/memory stages and the register file's `writeEnable`/`writeAddress`/`writeValue` inputs.

---
 rtl/regfile_writeback.sv | 124 ++++++++++++
 tb/tb_regfile_writeback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback sequencer for the register file write port.
// Zero-sweeps every register after reset, then merges load- and ALU-stage
// writeback requests through a small FIFO, retiring one write per cycle.
module regfile_writeback #(
    parameter int WIDTH   = 32,
    parameter int REGSIZE = 5,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memValid,
    input  logic [REGSIZE-1:0] memAddress,
    input  logic [WIDTH-1:0]   memValue,
    output logic               memReady,
    input  logic               aluValid,
    input  logic [REGSIZE-1:0] aluAddress,
    input  logic [WIDTH-1:0]   aluValue,
    output logic               aluReady,
    output logic               writeEnable,
    output logic [REGSIZE-1:0] writeAddress,
    output logic [WIDTH-1:0]   writeValue,
    output logic               initDone,
    output logic               busy
);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NREGS = 1 << REGSIZE;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state, nextState;
    logic [REGSIZE:0]   sweepCount;
    logic [REGSIZE-1:0] fifoAddr  [DEPTH];
    logic [WIDTH-1:0]   fifoValue [DEPTH];
    logic [PW-1:0]      rdPtr, wrPtr, aluSlot;
    logic [PW:0]        count;
    logic [PW+1:0]      freeSlots;
    logic               pop, memUses, memPush, aluPush, sweepEnd;

    // Sweep completes once every register address has been strobed.
    always_comb begin
        sweepEnd  = (state == INIT) && (sweepCount == (REGSIZE+1)'(NREGS));
        nextState = state;
        if (sweepEnd)
            nextState = RUN;
    end

    // Handshake and FIFO slot accounting; a pop this edge frees a slot,
    // and address-0 requests are swallowed without using space.
    always_comb begin
        pop       = (state == RUN) && (count != '0);
        freeSlots = (PW+2)'(DEPTH) - (PW+2)'(count) + (PW+2)'(pop);
        memUses   = memValid && (memAddress != '0);
        memReady  = (state == RUN) && (freeSlots >= (PW+2)'(1));
        aluReady  = (state == RUN) &&
                    (memUses ? (freeSlots >= (PW+2)'(2)) : (freeSlots >= (PW+2)'(1)));
        memPush   = memValid && memReady && (memAddress != '0);
        aluPush   = aluValid && aluReady && (aluAddress != '0);
        // Load is the older instruction, so it takes the first free slot.
        aluSlot   = wrPtr + PW'(memPush);
    end

    assign busy = (count != '0) || writeEnable;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= INIT;
        else
            state <= nextState;
    end

    // Write-port registers: zero sweep during INIT, FIFO head during RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweepCount   <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeValue   <= '0;
            initDone     <= 1'b0;
        end else if (state == INIT) begin
            if (sweepEnd) begin
                writeEnable <= 1'b0;
                initDone    <= 1'b1;
            end else begin
                writeEnable  <= 1'b1;
                writeAddress <= sweepCount[REGSIZE-1:0];
                writeValue   <= '0;
                sweepCount   <= sweepCount + 1'b1;
            end
        end else if (pop) begin
            writeEnable  <= 1'b1;
            writeAddress <= fifoAddr[rdPtr];
            writeValue   <= fifoValue[rdPtr];
        end else begin
            writeEnable <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; pushed entries become visible next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            wrPtr <= wrPtr + PW'(memPush) + PW'(aluPush);
            count <= count + (PW+1)'(memPush) + (PW+1)'(aluPush) - (PW+1)'(pop);
        end
    end

    // FIFO storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (memPush) begin
            fifoAddr[wrPtr]  <= memAddress;
            fifoValue[wrPtr] <= memValue;
        end
        if (aluPush) begin
            fifoAddr[aluSlot]  <= aluAddress;
            fifoValue[aluSlot] <= aluValue;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic checked
// against a queue-based model of the write sequencer and a register file model.
module tb_regfile_writeback;
    localparam int W  = 32;
    localparam int RS = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          memValid = 1'b0, aluValid = 1'b0;
    logic [RS-1:0] memAddress = '0, aluAddress = '0;
    logic [W-1:0]  memValue = '0, aluValue = '0;
    logic          memReady, aluReady, writeEnable, initDone, busy;
    logic [RS-1:0] writeAddress;
    logic [W-1:0]  writeValue;

    always #5 clk = ~clk;

    regfile_writeback #(.WIDTH(W), .REGSIZE(RS), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .memValid(memValid), .memAddress(memAddress), .memValue(memValue), .memReady(memReady),
        .aluValid(aluValid), .aluAddress(aluAddress), .aluValue(aluValue), .aluReady(aluReady),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .writeValue(writeValue),
        .initDone(initDone), .busy(busy)
    );

    typedef struct packed {
        logic          mr;
        logic          ar;
        logic          we;
        logic [RS-1:0] wa;
        logic [W-1:0]  wv;
        logic          busy;
        logic          initDone;
    } obs_t;

    typedef struct packed {
        logic [RS-1:0] a;
        logic [W-1:0]  v;
    } ent_t;

    // Reference model: pending writes in arrival order plus the write port.
    ent_t          q[$];
    logic [RS-1:0] lastA;
    logic [W-1:0]  lastV;
    logic          expWe, expInit;
    logic [W-1:0]  refRegs [32];
    logic [W-1:0]  dutRegs [32];
    int            pass = 0, total = 0;

    task automatic modelReset();
        q.delete();
        lastA = '0; lastV = '0; expWe = 1'b0; expInit = 1'b0;
    endtask

    task automatic setIdle();
        memValid = 1'b0; aluValid = 1'b0;
        memAddress = '0; aluAddress = '0; memValue = '0; aluValue = '0;
    endtask

    // One clock of traffic: readiness sampled at the falling edge, write port
    // sampled just after the rising edge; expectations come from the model.
    task automatic doCycle(input logic mv, input logic [RS-1:0] ma, input logic [W-1:0] mval,
                           input logic av, input logic [RS-1:0] aa, input logic [W-1:0] aval,
                           output obs_t got, output obs_t exp);
        int   free;
        logic memUses, mAcc, aAcc;
        ent_t h;
        memValid = mv; memAddress = ma; memValue = mval;
        aluValid = av; aluAddress = aa; aluValue = aval;
        @(negedge clk);
        free    = D - q.size() + ((q.size() != 0) ? 1 : 0);
        memUses = mv && (ma != 0);
        exp.mr  = expInit && (free >= 1);
        exp.ar  = expInit && (memUses ? (free >= 2) : (free >= 1));
        got.mr  = memReady;
        got.ar  = aluReady;
        mAcc    = mv && exp.mr;
        aAcc    = av && exp.ar;
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            h = q.pop_front();
            expWe = 1'b1; lastA = h.a; lastV = h.v;
            refRegs[h.a] = h.v;
        end else begin
            expWe = 1'b0;
        end
        if (mAcc && ma != 0) q.push_back({ma, mval});
        if (aAcc && aa != 0) q.push_back({aa, aval});
        exp.we = expWe; exp.wa = lastA; exp.wv = lastV;
        exp.busy = (q.size() != 0) || expWe;
        exp.initDone = expInit;
        got.we = writeEnable; got.wa = writeAddress; got.wv = writeValue;
        got.busy = busy; got.initDone = initDone;
        if (writeEnable) dutRegs[writeAddress] = writeValue;
    endtask

    // Releases reset (called with reset high, just after a rising edge) and
    // follows the 32-register zero sweep while both sources request.
    task automatic test_sweep();
        logic [RS+W:0] e;
        memValid = 1'b1; memAddress = 5'd9;  memValue = 32'h5555_5555;
        aluValid = 1'b1; aluAddress = 5'd10; aluValue = 32'hAAAA_AAAA;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            total++;
            if ({memReady, aluReady, initDone} !== 3'b000)
                $display("FAIL sweep_ready reg%0d: got %b want 000", i, {memReady, aluReady, initDone});
            else pass++;
            @(posedge clk);
            #1;
            e = {1'b1, i[RS-1:0], 32'd0};
            total++;
            if ({writeEnable, writeAddress, writeValue} !== e)
                $display("FAIL sweep_write reg%0d: got %h want %h", i, {writeEnable, writeAddress, writeValue}, e);
            else pass++;
            if (writeEnable) dutRegs[writeAddress] = writeValue;
        end
        @(posedge clk);
        #1;
        total++;
        if ({writeEnable, initDone, writeAddress} !== {1'b0, 1'b1, 5'd31})
            $display("FAIL sweep_done: got %b want 0111111", {writeEnable, initDone, writeAddress});
        else pass++;
        setIdle();
        for (int r = 0; r < 32; r++) refRegs[r] = '0;
        q.delete();
        lastA = 5'd31; lastV = '0; expWe = 1'b0; expInit = 1'b1;
    endtask

    task automatic test_reset();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({memReady, aluReady, writeEnable, writeAddress, writeValue, busy, initDone} !== '0)
            $display("FAIL reset_values: got %h want 0",
                     {memReady, aluReady, writeEnable, writeAddress, writeValue, busy, initDone});
        else pass++;
        test_sweep();
    endtask

    task automatic test_single();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) doCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, got, exp);
            else        doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            total++;
            if (got !== exp) $display("FAIL single c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
    endtask

    task automatic test_same_reg();
        obs_t got, exp;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) doCycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, got, exp);
            else        doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            total++;
            if (got !== exp) $display("FAIL same_reg c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
    endtask

    task automatic test_addr_zero();
        obs_t got, exp;
        int   pulses = 0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       doCycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 32'hFFFF_FFFF, got, exp);
                1:       doCycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd8, 32'h88, got, exp);
                default: doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            endcase
            if (got.we) pulses++;
            total++;
            if (got !== exp) $display("FAIL addr_zero c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
        total++;
        if (pulses != 2) $display("FAIL addr_zero_pulses: got %0d want 2", pulses);
        else pass++;
    endtask

    task automatic test_full();
        obs_t got, exp;
        int   memAcc = 0, aluDrops = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 10)
                doCycle(1'b1, 5'($urandom_range(1, 31)), 32'h1000 + i,
                        1'b1, 5'($urandom_range(1, 31)), 32'h2000 + i, got, exp);
            else
                doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            if (i < 10 && got.mr) memAcc++;
            if (i < 10 && !got.ar) aluDrops++;
            total++;
            if (got !== exp) $display("FAIL full c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
        total++;
        if (memAcc != 10 || aluDrops == 0)
            $display("FAIL full_backpressure: got memAcc=%0d aluDrops=%0d want 10 and >0", memAcc, aluDrops);
        else pass++;
    endtask

    task automatic test_random();
        obs_t          got, exp;
        logic [RS-1:0] ma, aa;
        for (int i = 0; i < 308; i++) begin
            ma = 5'($urandom_range(0, 31));
            aa = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ma = '0;
            if ($urandom_range(0, 7) == 0) aa = '0;
            if (i < 300)
                doCycle(1'($urandom_range(0, 1)), ma, $urandom,
                        1'($urandom_range(0, 1)), aa, $urandom, got, exp);
            else
                doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            total++;
            if (got !== exp) $display("FAIL random c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
        for (int r = 0; r < 32; r++) begin
            total++;
            if (dutRegs[r] !== refRegs[r])
                $display("FAIL regfile r%0d: got %h want %h", r, dutRegs[r], refRegs[r]);
            else pass++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        for (int i = 0; i < 3; i++) begin
            doCycle(1'b1, 5'(20 + i), 32'hC000 + i, 1'b1, 5'(25 + i), 32'hD000 + i, got, exp);
            total++;
            if (got !== exp) $display("FAIL reset_mid_fill c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({memReady, aluReady, writeEnable, writeAddress, writeValue, busy, initDone} !== '0)
            $display("FAIL reset_mid_async: got %h want 0",
                     {memReady, aluReady, writeEnable, writeAddress, writeValue, busy, initDone});
        else pass++;
        modelReset();
        @(posedge clk);
        #1;
        test_sweep();
        for (int i = 0; i < 5; i++) begin
            doCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, got, exp);
            total++;
            if (got !== exp) $display("FAIL reset_mid_stale c%0d: got %h want %h", i, got, exp);
            else pass++;
        end
    endtask

    initial begin
        setIdle();
        test_reset();
        test_single();
        test_same_reg();
        test_addr_zero();
        test_full();
        test_random();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
